// File: rtl/rk8e_break_ctl_if.sv
// Bus bundle for rk8e_break_ctl: disk word port plus the CPU data break bus.
// master = the break controller, slave = the disk logic / CPU sequencer side.
interface rk8e_break_ctl_if;
  // disk word port
  logic        dev_valid;
  logic [0:11] dev_wdata;
  logic        dev_ready;
  logic        dev_ack;
  logic [0:11] dev_rdata;
  // CPU data break bus
  logic        data_break;
  logic        to_disk;
  logic        break_in_prog;
  logic [0:14] break_addr;
  logic [0:11] break_wdata;
  logic [0:11] break_rdata;

  modport master (
    input  dev_valid, dev_wdata, dev_ready, break_in_prog, break_rdata,
    output dev_ack, dev_rdata, data_break, to_disk, break_addr, break_wdata
  );

  modport slave (
    output dev_valid, dev_wdata, dev_ready, break_in_prog, break_rdata,
    input  dev_ack, dev_rdata, data_break, to_disk, break_addr, break_wdata
  );
endinterface

// File: rtl/rk8e_break_ctl.sv
// rk8e_break_ctl: RK8E device-side data break requester.
// Holds CA/WC/field for a transfer, requests one break per word and moves
// one 12-bit word between the disk word port and memory per granted break.
// Optional macro BREAK_FIELD_CARRY_EN: a CA rollover 7777->0000 also
// increments the field; otherwise CA wraps inside the starting field.
module rk8e_break_ctl (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [0:11]         ca_in,
  input  logic [0:11]         wc_in,
  input  logic [0:2]          field_in,
  input  logic                dir_in,
  rk8e_break_ctl_if.master    bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAITDEV = 3'd1,
    REQ     = 3'd2,
    GRANT   = 3'd3,
    STEP    = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [0:11] ca;
  logic [0:11] wc;
  logic [0:11] wc_inc;
  logic [0:2]  field;
  logic        dir;
  logic        to_disk_q;
  logic        data_break_q;
  logic [0:11] wdata_q;
  logic [0:11] rdata_q;
  logic        last_word;

  // WC counts up from -N; the word that brings it to zero is the last one.
  assign wc_inc    = wc + 12'd1;
  assign last_word = (wc_inc == 12'd0);

  assign bus.break_addr  = {field, ca};
  assign bus.break_wdata = wdata_q;
  assign bus.dev_rdata   = rdata_q;
  assign bus.data_break  = data_break_q;
  assign bus.to_disk     = to_disk_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a start outside IDLE and a grant outside REQ/GRANT are ignored.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = WAITDEV;
      WAITDEV: if (dir ? bus.dev_valid : bus.dev_ready) next_state = REQ;
      REQ:     if (bus.break_in_prog) next_state = GRANT;
      GRANT:   if (!bus.break_in_prog) next_state = STEP;
      STEP:    next_state = last_word ? IDLE : WAITDEV;
      default: next_state = IDLE;
    endcase
  end

  // Handshake pulses and status decoded from the current state.
  always_comb begin
    busy        = (state != IDLE);
    bus.dev_ack = ((state == WAITDEV) && dir && bus.dev_valid) ||
                  ((state == STEP) && !dir);
    done        = (state == STEP) && last_word;
  end

  // Registered break request: up for every cycle spent in REQ, down on the grant edge.
  always_ff @(posedge clk) begin
    if (reset) data_break_q <= 1'b0;
    else       data_break_q <= (next_state == REQ);
  end

  // Transfer registers: load on start, capture words, advance CA/WC after each break.
  always_ff @(posedge clk) begin
    if (reset) begin
      ca        <= 12'd0;
      wc        <= 12'd0;
      field     <= 3'd0;
      dir       <= 1'b0;
      to_disk_q <= 1'b0;
      wdata_q   <= 12'd0;
      rdata_q   <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ca        <= ca_in;
            wc        <= wc_in;
            field     <= field_in;
            dir       <= dir_in;
            to_disk_q <= ~dir_in;
          end
        end
        WAITDEV: begin
          if (dir && bus.dev_valid) wdata_q <= bus.dev_wdata;
        end
        GRANT: begin
          // keep the last word seen while the grant is up
          if (bus.break_in_prog && !dir) rdata_q <= bus.break_rdata;
        end
        STEP: begin
          ca <= ca + 12'd1;
          wc <= wc_inc;
`ifdef BREAK_FIELD_CARRY_EN
          if (ca == 12'o7777) field <= field + 3'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
